// File: rtl/seq_det_pkg.sv
// seq_det_pkg
//   Shared definitions for the serial pattern detector: control-state
//   encoding, state width and the legal parameter ranges checked at
//   elaboration time by the top level.
package seq_det_pkg;

  localparam int STATE_W = 2;

  // Control-state encoding. 2'b11 is never entered deliberately; the FSM
  // recovers from it to IDLE on the next edge.
  localparam logic [STATE_W-1:0] IDLE = 2'b00;
  localparam logic [STATE_W-1:0] FILL = 2'b01;  // fewer than W valid bits
  localparam logic [STATE_W-1:0] RUN  = 2'b10;  // history full

  // Legal parameter ranges.
  localparam int W_MIN     = 2;
  localparam int W_MAX     = 16;
  localparam int CNT_W_MIN = 2;
  localparam int CNT_W_MAX = 16;

endpackage

// File: rtl/sat_counter.sv
// sat_counter
//   Saturating up-counter with a sticky saturation flag.
//   Ports:
//     clock   - rising-edge clock
//     reset_n - asynchronous active-low reset
//     inc     - add one (ignored once count is all-ones)
//     clr     - zero count and sat; wins over inc
//     count   - current count
//     sat     - set on the edge where count becomes all-ones, held until clr
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples the pre-edge values, independent of block order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (clr) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + 1'b1;
      if (count == CNT_MAX - 1'b1) sat <= 1'b1;
    end
  end

endmodule

// File: rtl/seq_detector.sv
// seq_detector
//   Serial pattern detector and controller. Shifts enabled samples of x into
//   a W-bit history and pulses match when the last W samples equal the
//   loaded pattern (MSB = oldest bit). Overlapping or non-overlapping
//   detection is selected per cycle; matches feed a saturating counter.
//   Ports:
//     clock, reset_n - rising-edge clock, asynchronous active-low reset
//     load, pattern  - capture pattern and restart detection
//     overlap        - 1: matches may share bits; 0: W fresh bits per match
//     en, x          - sample enable and serial data bit
//     clear          - zero count and sat
//     match          - registered one-cycle match pulse
//     count, sat     - saturating match count and sticky saturation flag
//     state          - control state (IDLE / FILL / RUN)
module seq_detector
  import seq_det_pkg::*;
#(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               load,
  input  logic [W-1:0]       pattern,
  input  logic               overlap,
  input  logic               en,
  input  logic               x,
  input  logic               clear,
  output logic               match,
  output logic [CNT_W-1:0]   count,
  output logic               sat,
  output logic [STATE_W-1:0] state
);

  if ((W < W_MIN) || (W > W_MAX)) begin : g_bad_w
    $error("seq_detector: W out of range");
  end
  if ((CNT_W < CNT_W_MIN) || (CNT_W > CNT_W_MAX)) begin : g_bad_cnt_w
    $error("seq_detector: CNT_W out of range");
  end

  localparam int               FILL_W    = $clog2(W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(W);

  logic [W-1:0]      pat_reg;
  logic [W-1:0]      hist;
  logic [W-1:0]      hist_next;
  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] fill_next;
  logic              sample;
  logic              hit;

  // NOTE: every signal driven here gets a value on every path, so no latch
  // can be inferred.
  always_comb begin
    // load pre-empts sampling; IDLE and the illegal encoding never sample.
    sample    = ((state == FILL) || (state == RUN)) && en && !load;
    hist_next = {hist[W-2:0], x};
    fill_next = (fill == FILL_FULL) ? FILL_FULL : fill + 1'b1;
    hit       = sample && (fill_next == FILL_FULL) && (hist_next == pat_reg);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      match   <= 1'b0;
      pat_reg <= '0;
      hist    <= '0;
      fill    <= '0;
    end else begin
      match <= hit;
      case (state)
        IDLE: begin
          if (load) begin
            pat_reg <= pattern;
            hist    <= '0;
            fill    <= '0;
            state   <= FILL;
          end
        end
        FILL, RUN: begin
          if (load) begin
            pat_reg <= pattern;
            hist    <= '0;
            fill    <= '0;
            state   <= FILL;
          end else if (en) begin
            hist <= hist_next;
            if (hit && !overlap) begin
              // Non-overlapping: discard the matched bits so the next match
              // needs W fresh samples.
              fill  <= '0;
              state <= FILL;
            end else begin
              fill  <= fill_next;
              state <= (fill_next == FILL_FULL) ? RUN : FILL;
            end
          end
        end
        default: begin
          state <= IDLE;
          hist  <= '0;
          fill  <= '0;
        end
      endcase
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_sat_counter (
    .clock  (clock),
    .reset_n(reset_n),
    .inc    (hit),
    .clr    (clear),
    .count  (count),
    .sat    (sat)
  );

endmodule
